lfsr_gen: RTL and testbench



---
 rtl/lfsr_gen.sv | 122 ++++++++++++
 tb/tb_lfsr_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, step enable, lockup detection and period measurement.
// Optional build macro LFSR_AUTO_RECOVER_EN: an all-zero load self-heals to DEFAULT_SEED after one cycle.
module lfsr_gen #(
  parameter int                WIDTH        = 11,
  parameter logic [WIDTH-1:0]  TAPS         = WIDTH'(11'h500),
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             lockup,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } fsm_t;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  fsm_t             fsm, fsm_nxt;
  logic [WIDTH-1:0] state, state_nxt;
  logic [WIDTH-1:0] ref_seed, ref_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] len_nxt;
  logic             done_nxt;

  logic [WIDTH-1:0] adv;
  logic             step_ok;
  logic             cnt_max;
  logic             wrap;
  logic             seed_zero;
  logic             recover;

  assign adv       = lfsr_next(state);
  assign seed_zero = (seed == '0);
  assign step_ok   = step && !seed_load && (fsm != LOCKED);
  assign cnt_max   = &cnt;
  // A saturated counter can no longer report a truthful length, so it suppresses the pulse.
  assign wrap      = step_ok && (adv == ref_seed) && !cnt_max;

`ifdef LFSR_AUTO_RECOVER_EN
  assign recover = (fsm == LOCKED) && !(seed_load && !seed_zero);
`else
  assign recover = 1'b0;
`endif

  // FSM next state
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE, RUN: begin
        if (seed_load)  fsm_nxt = seed_zero ? LOCKED : IDLE;
        else if (step)  fsm_nxt = (adv == '0) ? LOCKED : RUN;
      end
      LOCKED: begin
        if (recover)                       fsm_nxt = IDLE;
        else if (seed_load && !seed_zero)  fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Datapath next values: recovery, then load, then step
  always_comb begin
    state_nxt = state;
    ref_nxt   = ref_seed;
    cnt_nxt   = cnt;
    len_nxt   = period_len;
    done_nxt  = 1'b0;
    if (recover) begin
      state_nxt = DEFAULT_SEED;
      ref_nxt   = DEFAULT_SEED;
      cnt_nxt   = '0;
    end else if (seed_load) begin
      state_nxt = seed;
      ref_nxt   = seed;
      cnt_nxt   = '0;
    end else if (step_ok) begin
      state_nxt = adv;
      if (wrap) begin
        cnt_nxt  = '0;
        len_nxt  = cnt + 1'b1;
        done_nxt = 1'b1;
      end else if (!cnt_max) begin
        cnt_nxt  = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      state       <= DEFAULT_SEED;
      ref_seed    <= DEFAULT_SEED;
      cnt         <= '0;
      period_len  <= '0;
      period_done <= 1'b0;
    end else begin
      fsm         <= fsm_nxt;
      state       <= state_nxt;
      ref_seed    <= ref_nxt;
      cnt         <= cnt_nxt;
      period_len  <= len_nxt;
      period_done <= done_nxt;
    end
  end

  assign out    = state;
  assign valid  = (fsm == RUN);
  assign lockup = (fsm == LOCKED) && (state == '0);

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen (default build): sequence, full period, load priority, lockup, async reset.
module tb_lfsr_gen;

  localparam int WIDTH = 11;

  logic             clk;
  logic             rst_n;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             step;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic             lockup;
  logic             period_done;
  logic [WIDTH-1:0] period_len;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;
  int pulse_at;

  lfsr_gen #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_load   (seed_load),
    .seed        (seed),
    .step        (step),
    .out         (out),
    .valid       (valid),
    .lockup      (lockup),
    .period_done (period_done),
    .period_len  (period_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    step      = 1'b0;
    pulses    = 0;
    pulse_at  = 0;

    // Reset values
    #12;
    check("rst_out",    32'(out),         32'h001);
    check("rst_valid",  32'(valid),       32'h0);
    check("rst_lockup", 32'(lockup),      32'h0);
    check("rst_done",   32'(period_done), 32'h0);
    check("rst_len",    32'(period_len),  32'h0);
    rst_n = 1'b1;
    tick();
    check("idle_out",   32'(out),   32'h001);
    check("idle_valid", 32'(valid), 32'h0);

    // Default-seed sequence and full period
    step = 1'b1;
    for (int i = 1; i <= 2047; i++) begin
      tick();
      if (period_done) begin
        pulses++;
        pulse_at = i;
      end
      case (i)
        1:  begin
              check("s1_out",   32'(out),   32'h002);
              check("s1_valid", 32'(valid), 32'h1);
            end
        8:  check("s8_out",  32'(out), 32'h100);
        9:  check("s9_out",  32'(out), 32'h201);
        10: check("s10_out", 32'(out), 32'h402);
        11: check("s11_out", 32'(out), 32'h005);
        default: ;
      endcase
    end
    check("per_out",      32'(out),        32'h001);
    check("per_len",      32'(period_len), 32'h7FF);
    check("per_pulse_at", 32'(pulse_at),   32'd2047);
    step = 1'b0;
    tick();
    check("per_done_low", 32'(period_done), 32'h0);
    check("per_pulses",   32'(pulses),      32'd1);
    check("per_hold_out", 32'(out),         32'h001);

    // Load wins over step
    step = 1'b1;
    tick();
    tick();
    check("run_valid", 32'(valid), 32'h1);
    seed_load = 1'b1;
    seed      = 11'h3A5;
    tick();
    check("ld_out",   32'(out),        32'h3A5);
    check("ld_valid", 32'(valid),      32'h0);
    check("ld_len",   32'(period_len), 32'h7FF);
    seed_load = 1'b0;
    tick();
    check("ld_step_out",   32'(out),   32'h74B);
    check("ld_step_valid", 32'(valid), 32'h1);

    // MSB feeds back into bit 0
    step      = 1'b0;
    seed_load = 1'b1;
    seed      = 11'h400;
    tick();
    check("msb_idle_valid", 32'(valid), 32'h0);
    seed_load = 1'b0;
    step      = 1'b1;
    tick();
    check("msb_out1", 32'(out), 32'h001);
    tick();
    check("msb_out2", 32'(out), 32'h002);

    // Lockup: zero seed parks the generator
    seed_load = 1'b1;
    seed      = '0;
    step      = 1'b0;
    tick();
    seed_load = 1'b0;
    check("lk_out",    32'(out),    32'h000);
    check("lk_lockup", 32'(lockup), 32'h1);
    check("lk_valid",  32'(valid),  32'h0);
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lk_step_out",    32'(out),    32'h000);
      check("lk_step_lockup", 32'(lockup), 32'h1);
      check("lk_step_valid",  32'(valid),  32'h0);
    end
    step      = 1'b0;
    seed_load = 1'b1;
    seed      = 11'h001;
    tick();
    seed_load = 1'b0;
    check("lk_exit_lockup", 32'(lockup), 32'h0);
    check("lk_exit_out",    32'(out),    32'h001);
    check("lk_exit_valid",  32'(valid),  32'h0);
    step = 1'b1;
    tick();
    check("lk_exit_step", 32'(out), 32'h002);

    // Asynchronous reset mid-run
    for (int i = 0; i < 99; i++) tick();
    check("ar_pre_len", 32'(period_len), 32'h7FF);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_out",    32'(out),         32'h001);
    check("ar_valid",  32'(valid),       32'h0);
    check("ar_len",    32'(period_len),  32'h0);
    check("ar_done",   32'(period_done), 32'h0);
    check("ar_lockup", 32'(lockup),      32'h0);
    tick();
    check("ar_hold_out",  32'(out),         32'h001);
    check("ar_hold_done", 32'(period_done), 32'h0);
    step  = 1'b0;
    rst_n = 1'b1;
    tick();
    check("ar_rel_out",   32'(out),   32'h001);
    check("ar_rel_valid", 32'(valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
